// File: rtl/decoder_scan_ctrl_if.sv
// Bus between a scan controller and its user: scan commands in, decoder drive out.
// Optional feature macro: SCAN_HOLD_EN (adds the 'hold' freeze input after ch_mask).
interface decoder_scan_ctrl_if;
    logic       start;
    logic       stop;
    logic [7:0] ch_mask;
`ifdef SCAN_HOLD_EN
    logic       hold;
`endif
    logic [2:0] sel;
    logic       sel_en;
    logic       busy;
    logic       frame_done;

`ifdef SCAN_HOLD_EN
    modport master (output start, output stop, output ch_mask, output hold,
                    input sel, input sel_en, input busy, input frame_done);
    modport slave  (input start, input stop, input ch_mask, input hold,
                    output sel, output sel_en, output busy, output frame_done);
`else
    modport master (output start, output stop, output ch_mask,
                    input sel, input sel_en, input busy, input frame_done);
    modport slave  (input start, input stop, input ch_mask,
                    output sel, output sel_en, output busy, output frame_done);
`endif
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Round-robin scan sequencer for a 3-to-8 one-hot decoder.
// Each enabled channel is driven for DWELL_CYCLES with sel_en high, then
// BLANK_CYCLES with sel_en low, before moving to the next enabled channel.
// Optional feature macro: SCAN_HOLD_EN (hold input freezes an active scan).
module decoder_scan_ctrl #(
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_scan_ctrl_if.slave   bus
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

    state_t           state_reg;
    logic [2:0]       sel_reg;
    logic             sel_en_reg;
    logic             busy_reg;
    logic             frame_done_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [7:0]       rot_mask;
    logic [2:0]       first_sel;
    logic [2:0]       rot_first;
    logic [2:0]       next_sel;
    logic             mask_any;
    logic             wrap;
    logic             hold_active;

    // Index of the lowest set bit (0 when none is set; callers check mask_any).
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) idx = 3'(k);
        end
        return idx;
    endfunction

    // Mask rotated so that bit gi is the channel gi+1 places above the current
    // one; bit 7 is the current channel itself, so a lone channel picks itself.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_mask[gi] = bus.ch_mask[sel_reg + 3'(gi + 1)];
        end
    endgenerate

    assign mask_any  = |bus.ch_mask;
    assign first_sel = lowest_set(bus.ch_mask);
    assign rot_first = lowest_set(rot_mask);
    assign next_sel  = sel_reg + rot_first + 3'd1;
    assign wrap      = (next_sel <= sel_reg);

`ifdef SCAN_HOLD_EN
    assign hold_active = bus.hold;
`else
    assign hold_active = 1'b0;
`endif

    // Scan state machine; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            sel_en_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // stop has priority over start; an empty mask never starts
                    if (bus.start && !bus.stop && mask_any) begin
                        state_reg  <= DWELL;
                        sel_reg    <= first_sel;
                        sel_en_reg <= 1'b1;
                        busy_reg   <= 1'b1;
                        cnt_reg    <= '0;
                    end
                end
                DWELL, BLANK: begin
                    if (bus.stop) begin
                        state_reg  <= IDLE;
                        sel_en_reg <= 1'b0;
                        busy_reg   <= 1'b0;
                        cnt_reg    <= '0;
                    end else if (hold_active) begin
                        // frozen: state, counter, sel and sel_en all keep their value
                        state_reg <= state_reg;
                    end else if (state_reg == DWELL && cnt_reg != DWELL_LAST) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (state_reg == DWELL && HAS_BLANK) begin
                        state_reg  <= BLANK;
                        sel_en_reg <= 1'b0;
                        cnt_reg    <= '0;
                    end else if (state_reg == BLANK && cnt_reg != BLANK_LAST) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (!mask_any) begin
                        // mask emptied: park with sel held
                        state_reg  <= IDLE;
                        sel_en_reg <= 1'b0;
                        busy_reg   <= 1'b0;
                        cnt_reg    <= '0;
                    end else begin
                        // advance to next enabled channel, mask sampled now
                        state_reg      <= DWELL;
                        sel_reg        <= next_sel;
                        sel_en_reg     <= 1'b1;
                        cnt_reg        <= '0;
                        frame_done_reg <= wrap;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    sel_en_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    cnt_reg    <= '0;
                end
            endcase
        end
    end

    assign bus.sel        = sel_reg;
    assign bus.sel_en     = sel_en_reg;
    assign bus.busy       = busy_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: expected per-cycle outputs are
// queued when stimulus is applied and compared on each falling clock edge.
// Optional feature macro: SCAN_HOLD_EN (enables the hold scenario).
module tb_decoder_scan_ctrl;

    localparam int D = 4;
    localparam int B = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decoder_scan_ctrl_if bus();
    decoder_scan_ctrl_if bus0();

    decoder_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // second instance with no blanking gap
    decoder_scan_ctrl #(.DWELL_CYCLES(2), .BLANK_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    logic [5:0] q[$];
    logic [5:0] q0[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc_no = 0;
    string test_name = "init";

    task automatic push(input logic [2:0] s, input logic en, input logic b, input logic fd);
        q.push_back({s, en, b, fd});
    endtask

    task automatic push0(input logic [2:0] s, input logic en, input logic b, input logic fd);
        q0.push_back({s, en, b, fd});
    endtask

    // one channel visit: D dwell cycles then B blank cycles
    task automatic push_visit(input int ch, input logic fd);
        for (int d = 0; d < D; d++) push(3'(ch), 1'b1, 1'b1, (d == 0) ? fd : 1'b0);
        for (int b = 0; b < B; b++) push(3'(ch), 1'b0, 1'b1, 1'b0);
    endtask

    // n visits over the enabled channels in ascending order, wrapping
    task automatic push_scan(input logic [7:0] m, input int n, output int last);
        int list[$];
        int ch;
        for (int k = 0; k < 8; k++) if (m[k]) list.push_back(k);
        last = 0;
        for (int v = 0; v < n; v++) begin
            ch = list[v % list.size()];
            push_visit(ch, (v > 0) && (v % list.size() == 0));
            last = ch;
        end
    endtask

    task automatic cyc();
        logic [5:0] e;
        logic [5:0] got;
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got sel=%0d en=%b busy=%b fd=%b want sel=%0d en=%b busy=%b fd=%b",
                         test_name, cyc_no, got[5:3], got[2], got[1], got[0], e[5:3], e[2], e[1], e[0]);
            end else begin
                $display("ok   %s cyc=%0d sel=%0d en=%b busy=%b fd=%b",
                         test_name, cyc_no, got[5:3], got[2], got[1], got[0]);
            end
        end
        if (q0.size() > 0) begin
            e   = q0.pop_front();
            got = {bus0.sel, bus0.sel_en, bus0.busy, bus0.frame_done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s/noblank cyc=%0d got sel=%0d en=%b busy=%b fd=%b want sel=%0d en=%b busy=%b fd=%b",
                         test_name, cyc_no, got[5:3], got[2], got[1], got[0], e[5:3], e[2], e[1], e[0]);
            end else begin
                $display("ok   %s/noblank cyc=%0d sel=%0d en=%b busy=%b fd=%b",
                         test_name, cyc_no, got[5:3], got[2], got[1], got[0]);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // stop from an active scan: next cycle idle with sel held
    task automatic stop_scan(input int last);
        push(3'(last), 1'b0, 1'b0, 1'b0);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        test_name = "reset";
        rst = 1'b1;
        repeat (2) begin push(0, 0, 0, 0); push0(0, 0, 0, 0); end
        run(2);
        rst = 1'b0;
        bus.ch_mask = 8'hFF;          // mask alone must not start a scan
        push(0, 0, 0, 0);
        run(1);
    endtask

    task automatic test_full_mask();
        int last;
        test_name = "full_mask";
        bus.ch_mask = 8'hFF;
        push_scan(8'hFF, 17, last);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        run(17 * (D + B) - 1);
        stop_scan(last);
    endtask

    task automatic test_sparse();
        int last;
        test_name = "sparse";
        bus.ch_mask = 8'b1010_0100;
        push_scan(8'b1010_0100, 7, last);
        bus.start = 1'b1;             // held high: ignored while busy
        run(7 * (D + B));
        // start and stop together: stop wins, block stays idle
        push(3'(last), 0, 0, 0);
        push(3'(last), 0, 0, 0);
        bus.stop = 1'b1;
        run(2);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic test_single();
        int last;
        test_name = "single";
        bus.ch_mask = 8'h10;
        push_scan(8'h10, 4, last);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        run(4 * (D + B) - 1);
        stop_scan(last);
    endtask

    task automatic test_stop_mid();
        test_name = "stop_mid";
        bus.ch_mask = 8'b0000_1010;
        push_visit(1, 1'b0);
        push(3, 1, 1, 0);
        push(3, 1, 1, 0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        run(D + B + 1);
        stop_scan(3);                 // stop high during 2nd dwell cycle of ch 3
        test_name = "restart";
        push_visit(1, 1'b0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        run(D + B - 1);
        stop_scan(1);
    endtask

    task automatic test_mask_change();
        test_name = "mask_change";
        bus.ch_mask = 8'b0000_0011;
        push_visit(0, 1'b0);
        push_visit(7, 1'b0);
        push_visit(0, 1'b1);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        bus.ch_mask = 8'b1000_0001;   // takes effect only at the advance edge
        run(3 * (D + B) - 2);
        stop_scan(0);
    endtask

    task automatic test_mask_clear();
        test_name = "mask_clear";
        bus.ch_mask = 8'b0000_0110;
        push_visit(1, 1'b0);
        push(1, 0, 0, 0);
        push(1, 0, 0, 0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.ch_mask = 8'h00;
        run(D + B - 1 + 2);
    endtask

    task automatic test_rst_blank();
        test_name = "rst_blank";
        bus.ch_mask = 8'h20;
        push_visit(5, 1'b0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        run(D + B - 1);               // now showing the blank cycle
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_no_blank();
        test_name = "no_blank";
        bus0.ch_mask = 8'b0000_0011;
        for (int v = 0; v < 4; v++) begin
            push0(3'(v % 2), 1, 1, (v == 2) ? 1'b1 : 1'b0);
            push0(3'(v % 2), 1, 1, 0);
        end
        push0(1, 0, 0, 0);
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        run(7);
        bus0.stop = 1'b1;
        cyc();
        bus0.stop = 1'b0;
    endtask

`ifdef SCAN_HOLD_EN
    task automatic test_hold();
        test_name = "hold";
        bus.ch_mask = 8'h08;
        repeat (2 + 10 + D - 2) push(3, 1, 1, 0);
        for (int b = 0; b < B; b++) push(3, 0, 1, 0);
        push_visit(3, 1'b1);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        bus.hold = 1'b1;
        run(10);
        bus.hold = 1'b0;
        run(D - 2 + B + D + B);
        stop_scan(3);
    endtask
`endif

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.ch_mask  = 8'h00;
        bus0.start   = 1'b0;
        bus0.stop    = 1'b0;
        bus0.ch_mask = 8'h00;
`ifdef SCAN_HOLD_EN
        bus.hold     = 1'b0;
        bus0.hold    = 1'b0;
`endif
        test_reset();
        test_full_mask();
        test_sparse();
        test_single();
        test_stop_mid();
        test_mask_change();
        test_mask_clear();
        test_rst_blank();
        test_no_blank();
`ifdef SCAN_HOLD_EN
        test_hold();
`endif
        test_name = "drain";
        checks++;
        if (q.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL drain leftover entries got=%0d/%0d want=0/0", q.size(), q0.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout in %s got=running want=finished", test_name);
        $fatal(1, "timeout");
    end

endmodule
